profcnt_event_arbiter: RTL

Round-robin arbiter that shares one profiling event FIFO among `NUM_SRC` independent event sources, such as per-kernel counter snapshots.
- Each source fires single-cycle, non-stallable events.
- Each event is held in a one-entry slot per source.
- The held event is granted into the FIFO write port, tagged with its source ID.
- Events that arrive while their slot is still occupied are dropped and counted.

The block sits between the counter logic and the FIFO write side, and drives its enqueue/data inputs directly.

---
 rtl/profcnt_event_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/profcnt_event_arbiter.sv
// Round-robin arbiter feeding one profiling event FIFO from NUM_SRC one-entry event slots.
// Late events on an occupied slot are dropped and tallied in per-source saturating counters.
module profcnt_event_arbiter #(
    parameter int NUM_SRC       = 4,
    parameter int ID_WIDTH      = 2,
    parameter int PAYLOAD_WIDTH = 30,
    parameter int DROP_WIDTH    = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic                              clear_drops,
    input  logic [NUM_SRC-1:0]                src_event,
    input  logic [NUM_SRC*PAYLOAD_WIDTH-1:0]  src_data,
    input  logic                              fifo_full,
    output logic                              fifo_enqueue,
    output logic [ID_WIDTH+PAYLOAD_WIDTH-1:0] fifo_back,
    output logic [NUM_SRC-1:0]                pending,
    output logic [NUM_SRC*DROP_WIDTH-1:0]     drop_count
);

    localparam int IW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]       pending_q, pending_d;
    logic [PAYLOAD_WIDTH-1:0] data_q [NUM_SRC];
    logic [PAYLOAD_WIDTH-1:0] data_d [NUM_SRC];
    logic [DROP_WIDTH-1:0]    drop_q [NUM_SRC];
    logic [DROP_WIDTH-1:0]    drop_d [NUM_SRC];
    logic [IW-1:0]            last_q, last_d;
    logic [IW-1:0]            win;
    logic                     found;
    logic                     grant;

    // First pending slot searching upward from last_q+1, wrapping at NUM_SRC.
    always_comb begin
        int sum;
        win   = '0;
        found = 1'b0;
        sum   = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            sum = int'(last_q) + k;
            if (sum >= NUM_SRC) begin
                sum = sum - NUM_SRC;
            end
            if (!found && pending_q[IW'(sum)]) begin
                found = 1'b1;
                win   = IW'(sum);
            end
        end
    end

    // Gating with rst_n keeps the write strobe low before the first reset edge.
    assign grant        = rst_n & enable & ~fifo_full & found;
    assign fifo_enqueue = grant;
    assign fifo_back    = {ID_WIDTH'(win), data_q[win]};
    assign last_d       = grant ? win : last_q;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
            logic granted;
            logic load;
            logic drop;

            assign granted = grant && (win == IW'(gi));
            // A granted slot frees itself this edge, so a same-cycle event refills it instead of dropping.
            assign load    = src_event[gi] && (!pending_q[gi] || granted);
            assign drop    = src_event[gi] && pending_q[gi] && !granted;

            assign pending_d[gi] = load | (pending_q[gi] & ~granted);
            assign data_d[gi]    = load ? src_data[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] : data_q[gi];
            assign drop_d[gi]    = clear_drops ? '0 :
                                   (drop && (drop_q[gi] != '1)) ? drop_q[gi] + 1'b1 : drop_q[gi];

            assign pending[gi]                              = pending_q[gi];
            assign drop_count[gi*DROP_WIDTH +: DROP_WIDTH]  = drop_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            last_q    <= IW'(NUM_SRC - 1);
            for (int i = 0; i < NUM_SRC; i++) begin
                data_q[i] <= '0;
                drop_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            last_q    <= last_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                data_q[i] <= data_d[i];
                drop_q[i] <= drop_d[i];
            end
        end
    end

endmodule
